// File: rtl/e_mdu_pkg.sv
// Shared MDU op encodings and default latencies for the execute-stage multiply/divide unit.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational multiply/divide datapath: produces {hi, lo} for the op and flags divide by zero.
module mdu_arith
    import e_mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0
);

    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, uq, ur, sq, sr, dq, dr;

    assign prod_s = 64'($signed(a) * $signed(b));
    assign prod_u = 64'(a) * 64'(b);

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    assign mag_a = a[31] ? (32'd0 - a) : a;
    assign mag_b = b[31] ? (32'd0 - b) : b;

    always_comb begin
        uq = '0;
        ur = '0;
        dq = '0;
        dr = '0;
        if (b != '0) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
            dq = a / b;
            dr = a % b;
        end
    end

    assign sq = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
    assign sr = a[31] ? (32'd0 - ur) : ur;

    always_comb begin
        hi   = '0;
        lo   = '0;
        div0 = 1'b0;
        case (mdu_op_e'(op))
            MDU_MULT:  {hi, lo} = prod_s;
            MDU_MULTU: {hi, lo} = prod_u;
            MDU_DIV: begin
                hi   = sr;
                lo   = sq;
                div0 = (b == '0);
            end
            MDU_DIVU: begin
                hi   = dr;
                lo   = dq;
                div0 = (b == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage MDU: owns HI/LO, sequences multi-cycle mult/div, serves mthi/mtlo/mfhi/mflo.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_V1,
    input  logic [31:0] E_V2,
    input  logic        Req,
    output logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] E_MDUOut
);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, lo_q, hi_next_q, lo_next_q;
    logic               pend_we_q;
    logic [31:0]        ar_hi, ar_lo;
    logic               ar_div0;
    logic               is_mult, is_div, commit, mthi_we, mtlo_we;
    mdu_op_e            op;

    assign op      = mdu_op_e'(E_MDUOp);
    assign is_mult = (op == MDU_MULT) || (op == MDU_MULTU);
    assign is_div  = (op == MDU_DIV)  || (op == MDU_DIVU);
    assign E_Busy  = (state_q == S_BUSY);
    assign E_Start = (is_mult || is_div) && !Req && !E_Busy;
    assign mthi_we = (op == MDU_MTHI) && !Req && !E_Busy;
    assign mtlo_we = (op == MDU_MTLO) && !Req && !E_Busy;

    mdu_arith u_arith (
        .op   (E_MDUOp),
        .a    (E_V1),
        .b    (E_V2),
        .hi   (ar_hi),
        .lo   (ar_lo),
        .div0 (ar_div0)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (E_Start) begin
                    state_d = S_BUSY;
                    cnt_d   = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    commit  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            hi_next_q <= '0;
            lo_next_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (E_Start) begin
                hi_next_q <= ar_hi;
                lo_next_q <= ar_lo;
                pend_we_q <= !ar_div0;
            end
            // commit only happens while busy and mthi/mtlo only while idle, so they never collide
            if (commit && pend_we_q) begin
                hi_q <= hi_next_q;
                lo_q <= lo_next_q;
            end
            if (mthi_we) hi_q <= E_V1;
            if (mtlo_we) lo_q <= E_V1;
        end
    end

    always_comb begin
        case (op)
            MDU_MFHI: E_MDUOut = hi_q;
            MDU_MFLO: E_MDUOut = lo_q;
            default:  E_MDUOut = '0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus randomized ops against a 64-bit arithmetic model.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  E_MDUOp = OP_NONE;
    logic [31:0] E_V1 = '0;
    logic [31:0] E_V2 = '0;
    logic        Req = 1'b0;
    logic        E_Start;
    logic        E_Busy;
    logic [31:0] E_MDUOut;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_MDUOp  (E_MDUOp),
        .E_V1     (E_V1),
        .E_V2     (E_V2),
        .Req      (Req),
        .E_Start  (E_Start),
        .E_Busy   (E_Busy),
        .E_MDUOut (E_MDUOut)
    );

    always #5 clk = ~clk;

    // Reference: result of an op as {hi, lo}; ok=0 means divide by zero (no commit).
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output logic ok);
        longint sa, sb, q, r;
        logic [63:0] res;
        ok  = 1'b1;
        res = '0;
        if (op == OP_MULT) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            res = 64'(sa * sb);
        end else if (op == OP_MULTU) begin
            res = 64'(a) * 64'(b);
        end else begin
            if (op == OP_DIV) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            if (sb == 0) ok = 1'b0;
            else begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
        end
        return res;
    endfunction

    task automatic read_hilo(input string name);
        @(negedge clk);
        E_MDUOp = OP_MFHI;
        #1;
        checks++;
        if (E_MDUOut !== m_hi) begin
            errors++;
            $display("FAIL %s_hi got %h exp %h", name, E_MDUOut, m_hi);
        end
        E_MDUOp = OP_MFLO;
        #1;
        checks++;
        if (E_MDUOut !== m_lo) begin
            errors++;
            $display("FAIL %s_lo got %h exp %h", name, E_MDUOut, m_lo);
        end
        E_MDUOp = OP_NONE;
    endtask

    // Issue a mult/div, optionally spray ignored ops while busy, and measure busy length.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noise);
        logic [63:0] r;
        logic ok;
        int n;
        int exp_n;
        exp_n = (op == OP_MULT || op == OP_MULTU) ? MC : DC;
        r = model(op, a, b, ok);
        @(negedge clk);
        E_MDUOp = op;
        E_V1 = a;
        E_V2 = b;
        Req = 1'b0;
        #1;
        checks++;
        if (E_Start !== 1'b1) begin
            errors++;
            $display("FAIL %s_start got %b exp 1", name, E_Start);
        end
        @(negedge clk);
        E_MDUOp = OP_NONE;
        n = 0;
        while (E_Busy === 1'b1 && n < 40) begin
            if (noise) begin
                E_MDUOp = 4'($urandom_range(1, 6));
                E_V1 = $urandom;
                E_V2 = $urandom;
                Req = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (E_Start !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_start_busy got %b exp 0", name, E_Start);
                end
            end
            n++;
            @(negedge clk);
        end
        E_MDUOp = OP_NONE;
        Req = 1'b0;
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL %s_busy_len got %0d exp %0d", name, n, exp_n);
        end
        if (ok) {m_hi, m_lo} = r;
        read_hilo(name);
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] v, input logic req);
        @(negedge clk);
        E_MDUOp = op;
        E_V1 = v;
        Req = req;
        #1;
        checks++;
        if (E_Start !== 1'b0) begin
            errors++;
            $display("FAIL mt_start got %b exp 0", E_Start);
        end
        @(negedge clk);
        E_MDUOp = OP_NONE;
        Req = 1'b0;
        checks++;
        if (E_Busy !== 1'b0) begin
            errors++;
            $display("FAIL mt_busy got %b exp 0", E_Busy);
        end
        if (!req) begin
            if (op == OP_MTHI) m_hi = v;
            else m_lo = v;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        checks++;
        if (E_Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", E_Busy);
        end
        checks++;
        if (E_Start !== 1'b0) begin
            errors++;
            $display("FAIL reset_start got %b exp 0", E_Start);
        end
        m_hi = '0;
        m_lo = '0;
        read_hilo("reset");
    endtask

    task automatic test_mult;
        run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        checks++;
        if (m_hi !== 32'hFFFF_FFFF || m_lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult_model got %h_%h exp ffffffff_ffffffeb", m_hi, m_lo);
        end
        run_op("multu_big", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_div;
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        checks++;
        if (m_hi !== 32'hFFFF_FFFF || m_lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_model got %h_%h exp ffffffff_fffffffd", m_hi, m_lo);
        end
    endtask

    task automatic test_mt_mf;
        do_mt(OP_MTLO, 32'h0000_1234, 1'b0);
        read_hilo("mtlo");
        do_mt(OP_MTHI, 32'hCAFE_0001, 1'b0);
        read_hilo("mthi");
    endtask

    task automatic test_req;
        @(negedge clk);
        E_MDUOp = OP_MULTU;
        E_V1 = 32'd9;
        E_V2 = 32'd9;
        Req = 1'b1;
        #1;
        checks++;
        if (E_Start !== 1'b0) begin
            errors++;
            $display("FAIL req_start got %b exp 0", E_Start);
        end
        @(negedge clk);
        E_MDUOp = OP_NONE;
        Req = 1'b0;
        checks++;
        if (E_Busy !== 1'b0) begin
            errors++;
            $display("FAIL req_busy got %b exp 0", E_Busy);
        end
        read_hilo("req_nostart");
        do_mt(OP_MTHI, 32'hDEAD_BEEF, 1'b1);
        read_hilo("req_mthi");
        // Req asserted in busy cycle 3 must not stop the in-flight mult
        @(negedge clk);
        E_MDUOp = OP_MULT;
        E_V1 = 32'd1000;
        E_V2 = 32'hFFFF_FF00;
        #1;
        @(negedge clk);
        E_MDUOp = OP_NONE;
        @(negedge clk);
        @(negedge clk);
        Req = 1'b1;
        @(negedge clk);
        Req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (E_Busy !== 1'b0) begin
            errors++;
            $display("FAIL req_inflight_busy got %b exp 0", E_Busy);
        end
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFC_1800;
        read_hilo("req_inflight");
    endtask

    task automatic test_div0;
        do_mt(OP_MTHI, 32'd5, 1'b0);
        do_mt(OP_MTLO, 32'd6, 1'b0);
        run_op("div0", OP_DIV, 32'd77, 32'd0, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if (m_hi !== 32'h0 || m_lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL ovf_model got %h_%h exp 00000000_80000000", m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        E_MDUOp = OP_DIV;
        E_V1 = 32'd50;
        E_V2 = 32'd3;
        @(negedge clk);
        E_MDUOp = OP_NONE;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (E_Busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy got %b exp 0", E_Busy);
        end
        m_hi = '0;
        m_lo = '0;
        read_hilo("midreset");
        repeat (DC + 2) @(negedge clk);
        read_hilo("midreset_late");
    endtask

    task automatic test_random;
        logic [3:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(1, 6));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) b = -b;
            if (op == OP_MTHI || op == OP_MTLO) begin
                do_mt(op, a, 1'b0);
                read_hilo("rand_mt");
            end else begin
                run_op("rand_op", op, a, b, 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_mf();
        test_req();
        test_div0();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
